ip_matrix_2x2_seq_mult_det: RTL and testbench
=============================================

// Module: ip_matrix_2x2_seq_mult_det
// PURPOSE
//  Avalon-MM slave that computes C = A x B for two 2x2 signed matrices, then det(C).
//  Next generation of the 2x2 multiplier/determinant IP: element width is parametrised,
//  and each element has its own register. Work is sequenced through one shared signed multiplier.
//  Software sees a start/busy/done handshake, sticky error flags and an optional interrupt.
//  Sits on the HPS-to-FPGA lightweight bus next to the other custom IPs.
// PARAMETERS
//  W  7  signed element width of A and B, legal range 2..7 (det(C) must fit in 4W+3 <= 31 bits)
// PORTS
//  clock       in   1   system clock, all logic rising-edge
//  reset       in   1   synchronous, active-high
//  writedata   in   32  Avalon write data
//  readdata    out  32  Avalon read data, zero wait-states, combinational from in_address
//  write       in   1   Avalon write strobe
//  read        in   1   Avalon read strobe (no read side effects)
//  chipselect  in   1   slave select; write takes effect only when chipselect&write
//  in_address  in   4   word address
//  irq         out  1   level interrupt = done & irq_en
// BEHAVIOUR
//  Register map, read/write (R/W):
//  - 0-3: A00, A01, A10, A11 (R/W). Each captures writedata[W-1:0] as signed. Reads return the value sign-extended.
//  - 4-7: B00, B01, B10, B11 (R/W), same format as A.
//  - 8: CONTROL (W). bit0 = start (self-clearing), bit1 = irq_en (held), bit2 = clr_done (self-clearing). Reads return {30'b0, irq_en, 1'b0}.
//  - 9: STATUS (R). bit0 = busy, bit1 = done, bit2 = err. Writing 1 to bit2 clears err.
//  - 10-13: C00, C01, C10, C11 (R). Each is 2W+1 bits, sign-extended to 32.
//  - 14: DET (R). 4W+3 bits, sign-extended to 32.
//  - 15: reads 0; writes are ignored.
//  Reset: all A, B, C and DET registers = 0; irq_en = 0; busy = 0; done = 0; err = 0; irq = 0; FSM = IDLE.
//  FSM states: IDLE -> CALC -> IDLE. A 4-bit step counter cnt runs 0..9.
//  - IDLE: a start write on edge E moves the FSM to CALC, sets cnt = 0, busy = 1 and done = 0.
//  - CALC: one product per cycle through the single (2W+1)x(2W+1) signed multiplier. Operands are sign-extended.
//    - cnt 0-7: C00 = A00*B00 + A01*B10, C01 = A00*B01 + A01*B11, C10 = A10*B00 + A11*B10, C11 = A10*B01 + A11*B11.
//      Each element takes two consecutive steps: the first loads the accumulator, the second adds.
//    - cnt 8: p = C00*C11.
//    - cnt 9: DET = p - C01*C10. On this edge the FSM returns to IDLE, busy = 0 and done = 1.
//  Latency: done and busy = 0 are visible after edge E+10. C registers update as each element finishes.
//  No overflow is possible for W <= 7, so there is no saturation.
//  While busy:
//  - Writes to A, B, a start write, or a write with address 15 are ignored and set err (sticky).
//  - Writes to irq_en and clr_done are still accepted.
//  Simultaneous events:
//  - clr_done on the same edge that done is set: set wins.
//  - start together with clr_done in IDLE: the start is taken and done = 0.
//  - err clear together with a new err cause: set wins.
//  Back-to-back: start may be issued on the edge after done rises. The previous C and DET are overwritten step by step.
//  Reset mid-CALC: aborts on the next edge and applies all reset values. No partial result is flagged.
//  irq is registered-free: irq = done & irq_en, so it drops in the same cycle as clr_done or start clears done.
// TESTING
//  1. Load A = [1 2; 3 4], B = [5 6; 7 8], then start.
//     -> C = 19, 22, 43, 50; DET = 0x00000004.
//     -> done at exactly edge E+10; busy is high for 10 cycles.
//  2. Load A = [-64 0; 0 -64], B = [63 0; 0 -64], then start.
//     -> C00 = 0xFFFFF040 (-4032), C11 = 0x00001000, C01 = C10 = 0; DET = 0xFF040000.
//  3. Start, then at E+3 write A00 = 9 and issue start again.
//     -> err = 1; the A00 readback is unchanged; the test-1 results are still produced at E+10.
//  4. Set irq_en = 1 and run test 1. -> irq rises with done.
//     Then write clr_done at the done edge. -> done stays 1. Write clr_done again. -> irq = 0.
//  5. Assert reset at E+5 for 1 cycle. -> busy = 0, done = 0, C = 0, DET = 0, irq_en = 0.
//     A fresh start then completes normally.
//  6. With W = 4, load A = B = [-8 -8; -8 -8].
//     -> C = 128 each (0x00000080); DET = 0. Address 15 reads 0x00000000.

Source files
------------

// File: rtl/ip_matrix_2x2_seq_mult_det_if.sv
// Avalon-MM slave bus bundle for the 2x2 matrix multiply / determinant IP.
// The master side drives address, strobes and write data; the slave returns read data and irq.
interface ip_matrix_2x2_seq_mult_det_if;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [3:0]  in_address;
  logic        irq;

  modport master (
    output writedata, write, read, chipselect, in_address,
    input  readdata, irq
  );

  modport slave (
    input  writedata, write, read, chipselect, in_address,
    output readdata, irq
  );
endinterface

// File: rtl/ip_matrix_2x2_seq_mult_det.sv
// 2x2 signed matrix product C = A x B followed by det(C), sequenced through one
// shared signed multiplier over ten steps, exposed as an Avalon-MM register slave.
module ip_matrix_2x2_seq_mult_det #(
  parameter int W = 7
) (
  input  logic                         clock,
  input  logic                         reset,
  ip_matrix_2x2_seq_mult_det_if.slave  bus
);

  localparam int CW = 2 * W + 1;
  localparam int PW = 4 * W + 2;
  localparam int DW = 4 * W + 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  logic [0:0]              state_r;
  logic [3:0]              cnt_r;
  logic signed [W-1:0]     a_r [4];
  logic signed [W-1:0]     b_r [4];
  logic signed [CW-1:0]    c_r [4];
  logic signed [CW-1:0]    acc_r;
  logic signed [PW-1:0]    p_r;
  logic signed [DW-1:0]    det_r;
  logic                    irq_en_r;
  logic                    done_r;
  logic                    err_r;

  logic                    wr_s;
  logic                    busy_s;
  logic                    start_s;
  logic                    clr_done_s;
  logic                    err_clr_s;
  logic                    ab_wr_s;
  logic                    illegal_s;
  logic signed [W-1:0]     a_sel_s;
  logic signed [W-1:0]     b_sel_s;
  logic signed [CW-1:0]    op_a_s;
  logic signed [CW-1:0]    op_b_s;
  logic signed [PW-1:0]    prod_s;
  logic [1:0]              c_idx_s;
  logic [31:0]             rdata_s;
  logic                    unused_s;

  function automatic logic [31:0] sext_ab(input logic signed [W-1:0] v);
    return {{(32 - W){v[W-1]}}, v};
  endfunction

  function automatic logic [31:0] sext_c(input logic signed [CW-1:0] v);
    return {{(32 - CW){v[CW-1]}}, v};
  endfunction

  function automatic logic [31:0] sext_det(input logic signed [DW-1:0] v);
    return {{(32 - DW){v[DW-1]}}, v};
  endfunction

  assign wr_s       = bus.chipselect & bus.write;
  assign busy_s     = (state_r == ST_CALC);
  assign start_s    = wr_s && (bus.in_address == 4'd8) && bus.writedata[0];
  assign clr_done_s = wr_s && (bus.in_address == 4'd8) && bus.writedata[2];
  assign err_clr_s  = wr_s && (bus.in_address == 4'd9) && bus.writedata[2];
  assign ab_wr_s    = wr_s && !bus.in_address[3];
  assign illegal_s  = busy_s && (ab_wr_s || start_s || (wr_s && (bus.in_address == 4'd15)));
  assign unused_s   = ^{bus.writedata, bus.read};

  // Operand select: steps 0-7 walk row i = cnt[2], col j = cnt[1], term k = cnt[0].
  always_comb begin
    a_sel_s = a_r[{cnt_r[2], cnt_r[0]}];
    b_sel_s = b_r[{cnt_r[0], cnt_r[1]}];
    op_a_s  = '0;
    op_b_s  = '0;
    if (!cnt_r[3]) begin
      op_a_s = {{(CW - W){a_sel_s[W-1]}}, a_sel_s};
      op_b_s = {{(CW - W){b_sel_s[W-1]}}, b_sel_s};
    end else if (cnt_r == 4'd8) begin
      op_a_s = c_r[0];
      op_b_s = c_r[3];
    end else begin
      op_a_s = c_r[1];
      op_b_s = c_r[2];
    end
  end

  assign prod_s = op_a_s * op_b_s;

  // Register file, sequencer and datapath state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      acc_r    <= '0;
      p_r      <= '0;
      det_r    <= '0;
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
        c_r[i] <= '0;
      end
    end else begin
      if (ab_wr_s && !busy_s) begin
        if (!bus.in_address[2]) begin
          a_r[bus.in_address[1:0]] <= bus.writedata[W-1:0];
        end else begin
          b_r[bus.in_address[1:0]] <= bus.writedata[W-1:0];
        end
      end

      if (wr_s && (bus.in_address == 4'd8)) begin
        irq_en_r <= bus.writedata[1];
      end

      if (illegal_s) begin
        err_r <= 1'b1;
      end else if (err_clr_s) begin
        err_r <= 1'b0;
      end

      // Completion beats a concurrent clr_done; an idle start clears done.
      if (busy_s && (cnt_r == 4'd9)) begin
        done_r <= 1'b1;
      end else if ((start_s && !busy_s) || clr_done_s) begin
        done_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_CALC;
            cnt_r   <= 4'd0;
          end
        end
        ST_CALC: begin
          if (!cnt_r[3]) begin
            if (!cnt_r[0]) begin
              acc_r <= prod_s[CW-1:0];
            end else begin
              c_r[cnt_r[2:1]] <= acc_r + prod_s[CW-1:0];
            end
          end else if (cnt_r == 4'd8) begin
            p_r <= prod_s;
          end else begin
            det_r <= {p_r[PW-1], p_r} - {prod_s[PW-1], prod_s};
          end
          if (cnt_r == 4'd9) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign c_idx_s = bus.in_address[1:0] - 2'd2;

  // Zero-wait-state read mux.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.in_address)
      4'd0, 4'd1, 4'd2, 4'd3:     rdata_s = sext_ab(a_r[bus.in_address[1:0]]);
      4'd4, 4'd5, 4'd6, 4'd7:     rdata_s = sext_ab(b_r[bus.in_address[1:0]]);
      4'd8:                       rdata_s = {30'd0, irq_en_r, 1'b0};
      4'd9:                       rdata_s = {29'd0, err_r, done_r, busy_s};
      4'd10, 4'd11, 4'd12, 4'd13: rdata_s = sext_c(c_r[c_idx_s]);
      4'd14:                      rdata_s = sext_det(det_r);
      default:                    rdata_s = 32'd0;
    endcase
  end

  assign bus.readdata = rdata_s;
  assign bus.irq      = done_r & irq_en_r;

endmodule

// File: tb/tb_ip_matrix_2x2_seq_mult_det.sv
// Directed, table-driven bench for the 2x2 sequential multiply/determinant IP
// (W = 7 instance for the main tests, W = 4 instance for the narrow-width case).
module tb_ip_matrix_2x2_seq_mult_det;

  typedef struct {
    int a[4];
    int b[4];
    int c[4];
    int det;
  } vec_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[4];

  ip_matrix_2x2_seq_mult_det_if bus7 ();
  ip_matrix_2x2_seq_mult_det_if bus4 ();

  ip_matrix_2x2_seq_mult_det #(.W(7)) dut7 (.clock(clock), .reset(reset), .bus(bus7));
  ip_matrix_2x2_seq_mult_det #(.W(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input bit sel, input logic [3:0] addr, input logic [31:0] data);
    if (sel) begin
      bus4.chipselect = 1'b1; bus4.write = 1'b1; bus4.in_address = addr; bus4.writedata = data;
    end else begin
      bus7.chipselect = 1'b1; bus7.write = 1'b1; bus7.in_address = addr; bus7.writedata = data;
    end
    @(posedge clock);
    #1;
    bus4.chipselect = 1'b0; bus4.write = 1'b0;
    bus7.chipselect = 1'b0; bus7.write = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk_rd(input bit sel, input logic [3:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    if (sel) begin
      bus4.in_address = addr; bus4.read = 1'b1;
    end else begin
      bus7.in_address = addr; bus7.read = 1'b1;
    end
    #1;
    d = sel ? bus4.readdata : bus7.readdata;
    bus4.read = 1'b0;
    bus7.read = 1'b0;
    chk(name, d, exp);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) wr(1'b0, 4'(i), 32'(v.a[i]));
    for (int i = 0; i < 4; i++) wr(1'b0, 4'(4 + i), 32'(v.b[i]));
  endtask

  task automatic chk_result(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) chk_rd(1'b0, 4'(10 + i), 32'(v.c[i]), $sformatf("%s_c%0d", tag, i));
    chk_rd(1'b0, 4'd14, 32'(v.det), {tag, "_det"});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    load(v);
    chk_rd(1'b0, 4'd0, 32'(v.a[0]), {tag, "_a00_rb"});
    chk_rd(1'b0, 4'd7, 32'(v.b[3]), {tag, "_b11_rb"});
    wr(1'b0, 4'd8, 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk_rd(1'b0, 4'd9, 32'h1, $sformatf("%s_busy%0d", tag, i));
      tick(1);
    end
    chk_rd(1'b0, 4'd9, 32'h2, {tag, "_done"});
    chk(tag, {31'd0, bus7.irq}, 32'h0);
    chk_result(v, tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0].a = '{1, 2, 3, 4};         vecs[0].b = '{5, 6, 7, 8};
    vecs[0].c = '{19, 22, 43, 50};     vecs[0].det = 4;
    vecs[1].a = '{-64, 0, 0, -64};     vecs[1].b = '{63, 0, 0, -64};
    vecs[1].c = '{-4032, 0, 0, 4096};  vecs[1].det = 32'hFF040000;
    vecs[2].a = '{-3, 5, 7, -2};       vecs[2].b = '{4, -6, -1, 8};
    vecs[2].c = '{-17, 58, 30, -58};   vecs[2].det = -754;
    vecs[3].a = '{63, -64, -64, 63};   vecs[3].b = '{-64, 63, 63, -64};
    vecs[3].c = '{-8064, 8065, 8065, -8064}; vecs[3].det = -16129;

    bus7.writedata = 32'd0; bus7.write = 1'b0; bus7.read = 1'b0; bus7.chipselect = 1'b0; bus7.in_address = 4'd0;
    bus4.writedata = 32'd0; bus4.write = 1'b0; bus4.read = 1'b0; bus4.chipselect = 1'b0; bus4.in_address = 4'd0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state: every register reads zero, irq low.
    for (int i = 0; i < 16; i++) chk_rd(1'b0, 4'(i), 32'h0, $sformatf("rst_addr%0d", i));
    chk("rst_irq", {31'd0, bus7.irq}, 32'h0);

    for (int n = 0; n < 4; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Illegal writes while busy: err set, A00 untouched, results still on time.
    load(vecs[0]);
    wr(1'b0, 4'd8, 32'h1);
    tick(2);
    wr(1'b0, 4'd0, 32'd9);
    wr(1'b0, 4'd8, 32'h1);
    tick(5);
    chk_rd(1'b0, 4'd9, 32'h5, "err_busy");
    tick(1);
    chk_rd(1'b0, 4'd9, 32'h6, "err_done");
    chk_rd(1'b0, 4'd0, 32'h1, "err_a00_kept");
    chk_result(vecs[0], "err");
    wr(1'b0, 4'd9, 32'h4);
    chk_rd(1'b0, 4'd9, 32'h2, "err_clear");
    wr(1'b0, 4'd15, 32'hFFFFFFFF);
    chk_rd(1'b0, 4'd9, 32'h2, "idle_a15_no_err");
    chk_rd(1'b0, 4'd15, 32'h0, "a15_read");

    // irq behaviour and clr_done racing the done edge.
    wr(1'b0, 4'd8, 32'h2);
    chk_rd(1'b0, 4'd8, 32'h2, "ctrl_irq_en");
    chk("irq_old_done", {31'd0, bus7.irq}, 32'h1);
    wr(1'b0, 4'd8, 32'h3);
    chk("irq_start_drop", {31'd0, bus7.irq}, 32'h0);
    tick(9);
    chk("irq_before_done", {31'd0, bus7.irq}, 32'h0);
    wr(1'b0, 4'd8, 32'h6);
    chk_rd(1'b0, 4'd9, 32'h2, "clr_vs_set");
    chk("irq_rise", {31'd0, bus7.irq}, 32'h1);
    wr(1'b0, 4'd8, 32'h6);
    chk_rd(1'b0, 4'd9, 32'h0, "clr_done");
    chk("irq_clr", {31'd0, bus7.irq}, 32'h0);
    wr(1'b0, 4'd8, 32'h5);
    chk_rd(1'b0, 4'd9, 32'h1, "start_with_clr");
    tick(10);
    chk_rd(1'b0, 4'd9, 32'h2, "start_with_clr_done");
    chk_rd(1'b0, 4'd8, 32'h0, "ctrl_irq_off");

    // Reset in the middle of a calculation.
    wr(1'b0, 4'd8, 32'h3);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_rd(1'b0, 4'd9, 32'h0, "midrst_status");
    chk_rd(1'b0, 4'd8, 32'h0, "midrst_ctrl");
    chk_rd(1'b0, 4'd0, 32'h0, "midrst_a00");
    for (int i = 10; i < 15; i++) chk_rd(1'b0, 4'(i), 32'h0, $sformatf("midrst_addr%0d", i));
    chk("midrst_irq", {31'd0, bus7.irq}, 32'h0);
    run_vec(vecs[0], "after_rst");

    // Narrow instance: W = 4, all elements at the negative limit.
    wr(1'b1, 4'd0, 32'h18);
    for (int i = 1; i < 8; i++) wr(1'b1, 4'(i), 32'hFFFFFFF8);
    chk_rd(1'b1, 4'd0, 32'hFFFFFFF8, "w4_a00_trunc");
    wr(1'b1, 4'd8, 32'h1);
    tick(9);
    chk_rd(1'b1, 4'd9, 32'h1, "w4_busy");
    tick(1);
    chk_rd(1'b1, 4'd9, 32'h2, "w4_done");
    for (int i = 10; i < 14; i++) chk_rd(1'b1, 4'(i), 32'h00000080, $sformatf("w4_c%0d", i - 10));
    chk_rd(1'b1, 4'd14, 32'h0, "w4_det");
    chk_rd(1'b1, 4'd15, 32'h0, "w4_a15");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
